pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles in MEM_WAIT before forced exit (legal range 1-255).
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 hazard_detected  input  1  data hazard from the hazard detection unit for the instruction in ID.
REQ-006 branch_taken  input  1  branch resolved taken in EXE this cycle.
REQ-007 mem_access  input  1  instruction in MEM performs a load or store this cycle.
REQ-008 sram_ready  input  1  memory completes the current access this cycle (single-cycle pulse or level).
REQ-009 clear_counters  input  1  synchronous clear of counters and the sticky error.
REQ-010 freeze_front  output  1  hold PC and IF/ID register.
REQ-011 bubble_id_exe  output  1  load NOP into ID/EXE instead of the ID instruction.
REQ-012 flush_front  output  1  flush IF/ID and ID/EXE (branch squash).
REQ-013 freeze_all  output  1  hold PC and every pipeline register (memory wait).
REQ-014 state  output  2  current FSM state: 0 RUN, 1 MEM_WAIT.
REQ-015 mem_timeout  output  1  sticky error: a memory wait exceeded MEM_TIMEOUT.
REQ-016 stall_count  output  CNT_W  cycles with freeze_front or freeze_all high.
REQ-017 flush_count  output  CNT_W  cycles with flush_front high.

Function
REQ-018 freeze_front, bubble_id_exe, flush_front and freeze_all SHALL be combinational from the registered state and current inputs (same-cycle effect); state, counters and mem_timeout SHALL be registered.
REQ-019 RUN, priority 1: mem_access=1 and sram_ready=0 -> freeze_all=1, freeze_front=1, others 0; next state MEM_WAIT; wait counter loaded with 1.
REQ-020 RUN, priority 2: branch_taken=1 -> flush_front=1, all others 0 (hazard ignored; hazarding instruction is squashed); stay RUN.
REQ-021 RUN, priority 3: hazard_detected=1 -> freeze_front=1, bubble_id_exe=1, others 0; stay RUN.
REQ-022 RUN, mem_access=1 and sram_ready=1 same cycle: zero-wait access, no freeze; priorities 2/3 apply.
REQ-023 MEM_WAIT: branch_taken and hazard_detected SHALL be masked; bubble_id_exe=0, flush_front=0.
REQ-024 MEM_WAIT, sram_ready=0 and wait counter < MEM_TIMEOUT: freeze_all=1, freeze_front=1, wait counter +1, stay.
REQ-025 MEM_WAIT, sram_ready=1: freeze_all=0, freeze_front=0 this cycle (pipeline advances), next state RUN.
REQ-026 MEM_WAIT, sram_ready=0 and wait counter = MEM_TIMEOUT: freeze_all=0, freeze_front=0, mem_timeout set to 1, next state RUN.
REQ-027 sram_ready and timeout in the same cycle: treated as completion; mem_timeout unchanged.
REQ-028 Wait counter SHALL be 8 bits and never exceed MEM_TIMEOUT.
REQ-029 stall_count +1 each cycle freeze_front or freeze_all is 1; flush_count +1 each cycle flush_front is 1; both saturate at 2^CNT_W-1, no wrap.
REQ-030 clear_counters=1: both counters and mem_timeout to 0 next edge, overriding increments that cycle; FSM unaffected.
REQ-031 mem_timeout SHALL stay 1 until clear_counters or reset.

Reset
REQ-032 rst_n=0 at an edge: state RUN, wait counter 0, stall_count 0, flush_count 0, mem_timeout 0.
REQ-033 While rst_n=0, all combinational control outputs SHALL be forced to 0 regardless of inputs.
REQ-034 Reset asserted in MEM_WAIT SHALL abort the wait; first cycle after release is RUN with no freeze unless inputs demand it.

Verification
REQ-035 hazard_detected=1 for 2 cycles in RUN -> freeze_front=1, bubble_id_exe=1 both cycles; stall_count=2.
REQ-036 branch_taken=1 with hazard_detected=1 -> flush_front=1, freeze_front=0, bubble_id_exe=0; flush_count=1.
REQ-037 mem_access=1, sram_ready low 3 cycles then high -> freeze_all=1 for 3 cycles, 0 on ready cycle, state back to 0; stall_count=3.
REQ-038 MEM_TIMEOUT=4, mem_access=1, sram_ready never high -> freeze_all for 4 cycles, released 5th cycle, mem_timeout=1, state 0.
REQ-039 CNT_W=4, hazard held 20 cycles -> stall_count stops at 15; then clear_counters=1 -> stall_count=0, mem_timeout=0.
REQ-040 rst_n=0 during MEM_WAIT with branch_taken=1 -> all outputs 0; after release state=0, counters 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: converts hazard, branch and memory-wait
// conditions into freeze/bubble/flush controls and keeps performance counters.
module pipeline_stall_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             sram_ready,
   input  logic             clear_counters,
   output logic             freeze_front,
   output logic             bubble_id_exe,
   output logic             flush_front,
   output logic             freeze_all,
   output logic [1:0]       state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1
   } state_t;

   localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t     cur_state;
   state_t     next_state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_next;
   logic       timeout_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state <= RUN;
         wait_cnt  <= 8'd0;
      end else begin
         cur_state <= next_state;
         wait_cnt  <= wait_cnt_next;
      end
   end

   // Controls are gated by rst_n so nothing leaks out while the core is held in reset.
   always_comb begin
      next_state    = cur_state;
      wait_cnt_next = wait_cnt;
      freeze_front  = 1'b0;
      bubble_id_exe = 1'b0;
      flush_front   = 1'b0;
      freeze_all    = 1'b0;
      timeout_hit   = 1'b0;
      if (rst_n) begin
         case (cur_state)
            RUN: begin
               if (mem_access && !sram_ready) begin
                  freeze_all    = 1'b1;
                  freeze_front  = 1'b1;
                  next_state    = MEM_WAIT;
                  wait_cnt_next = 8'd1;
               end else if (branch_taken) begin
                  flush_front = 1'b1;
               end else if (hazard_detected) begin
                  freeze_front  = 1'b1;
                  bubble_id_exe = 1'b1;
               end
            end
            MEM_WAIT: begin
               // Completion wins over timeout when both land in the same cycle.
               if (sram_ready) begin
                  next_state    = RUN;
                  wait_cnt_next = 8'd0;
               end else if (wait_cnt < TIMEOUT_LIM) begin
                  freeze_all    = 1'b1;
                  freeze_front  = 1'b1;
                  wait_cnt_next = wait_cnt + 8'd1;
               end else begin
                  timeout_hit   = 1'b1;
                  next_state    = RUN;
                  wait_cnt_next = 8'd0;
               end
            end
            default: begin
               next_state    = RUN;
               wait_cnt_next = 8'd0;
            end
         endcase
      end
   end

   assign state = cur_state;

   // Saturating counters; clear_counters overrides any increment in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_counters) begin
         stall_count <= '0;
         flush_count <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if ((freeze_front || freeze_all) && (stall_count != CNT_MAX))
            stall_count <= stall_count + 1'b1;
         if (flush_front && (flush_count != CNT_MAX))
            flush_count <= flush_count + 1'b1;
         if (timeout_hit)
            mem_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller, using a short
// memory timeout and narrow counters so timeout and saturation are reachable.
module tb_pipeline_stall_controller;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;

   logic             clk;
   logic             rst_n;
   logic             hazard_detected;
   logic             branch_taken;
   logic             mem_access;
   logic             sram_ready;
   logic             clear_counters;
   logic             freeze_front;
   logic             bubble_id_exe;
   logic             flush_front;
   logic             freeze_all;
   logic [1:0]       state;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   int checkCount = 0;
   int passCount  = 0;

   pipeline_stall_controller #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hazard_detected(hazard_detected),
      .branch_taken   (branch_taken),
      .mem_access     (mem_access),
      .sram_ready     (sram_ready),
      .clear_counters (clear_counters),
      .freeze_front   (freeze_front),
      .bubble_id_exe  (bubble_id_exe),
      .flush_front    (flush_front),
      .freeze_all     (freeze_all),
      .state          (state),
      .mem_timeout    (mem_timeout),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      else
         passCount++;
   endtask

   // Drives inputs just after an edge, then lets the combinational outputs settle.
   task automatic applyStimulus(input logic h, input logic b, input logic m, input logic s, input logic c);
      hazard_detected = h;
      branch_taken    = b;
      mem_access      = m;
      sram_ready      = s;
      clear_counters  = c;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkComb(input string tag, input logic ff, input logic bub, input logic fl, input logic fa);
      checkOutput({tag, ".freeze_front"}, 32'(freeze_front), 32'(ff));
      checkOutput({tag, ".bubble_id_exe"}, 32'(bubble_id_exe), 32'(bub));
      checkOutput({tag, ".flush_front"}, 32'(flush_front), 32'(fl));
      checkOutput({tag, ".freeze_all"}, 32'(freeze_all), 32'(fa));
   endtask

   task automatic checkRegs(input string tag, input int st, input int stl, input int fls, input int tmo);
      checkOutput({tag, ".state"}, 32'(state), 32'(st));
      checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(stl));
      checkOutput({tag, ".flush_count"}, 32'(flush_count), 32'(fls));
      checkOutput({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(tmo));
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1, 1, 1, 0, 0);
      checkComb("rst_comb", 0, 0, 0, 0);
      tick();
      tick();
      checkRegs("rst_regs", 0, 0, 0, 0);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      checkComb("idle", 0, 0, 0, 0);
      tick();

      // Two-cycle hazard
      applyStimulus(1, 0, 0, 0, 0);
      checkComb("haz_c1", 1, 1, 0, 0);
      tick();
      checkComb("haz_c2", 1, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("haz_end", 0, 2, 0, 0);

      // Branch beats hazard
      applyStimulus(1, 1, 0, 0, 0);
      checkComb("br_haz", 0, 0, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("br_end", 0, 2, 1, 0);

      // Three-cycle memory wait, branch/hazard masked while waiting
      applyStimulus(0, 0, 1, 0, 0);
      checkComb("mw_c1", 1, 0, 0, 1);
      tick();
      checkOutput("mw_state1", 32'(state), 32'd1);
      applyStimulus(1, 1, 1, 0, 0);
      checkComb("mw_c2_masked", 1, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 1, 0, 0);
      checkComb("mw_c3", 1, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 1, 1, 0);
      checkComb("mw_ready", 0, 0, 0, 0);
      checkOutput("mw_state_ready", 32'(state), 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("mw_end", 0, 5, 1, 0);

      // Zero-wait access with hazard: no freeze_all, hazard handled
      applyStimulus(1, 0, 1, 1, 0);
      checkComb("zw_haz", 1, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("zw_end", 0, 6, 1, 0);

      // Timeout: four frozen cycles, released on the fifth
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         checkComb($sformatf("to_c%0d", i + 1), 1, 0, 0, 1);
         tick();
      end
      applyStimulus(0, 0, 1, 0, 0);
      checkComb("to_c5", 0, 0, 0, 0);
      checkOutput("to_c5_state", 32'(state), 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("to_end", 0, 10, 1, 1);
      tick();
      tick();
      checkOutput("to_sticky", 32'(mem_timeout), 32'd1);

      // Stall counter saturation, then clear overriding an increment
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      checkOutput("sat_stall", 32'(stall_count), 32'd15);
      applyStimulus(1, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("clear", 0, 0, 0, 0);

      // Ready arriving on the timeout cycle counts as completion
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 1, 1, 0);
      checkComb("rdy_at_to", 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkRegs("rdy_at_to_end", 0, 4, 0, 0);

      // Flush counter saturation
      applyStimulus(0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("sat_flush", 32'(flush_count), 32'd15);

      // Reset asserted mid-wait with a branch pending
      applyStimulus(0, 0, 1, 0, 0);
      tick();
      checkOutput("rw_state", 32'(state), 32'd1);
      rst_n = 1'b0;
      applyStimulus(0, 1, 1, 0, 0);
      checkComb("rw_comb", 0, 0, 0, 0);
      tick();
      checkRegs("rw_regs", 0, 0, 0, 0);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      checkComb("rw_release", 0, 0, 0, 0);
      tick();
      checkRegs("rw_after", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
